qea_job_sequencer: RTL and testbench

//  Host-side controller that runs one complete circuit job on a QEA instance without testbench involvement.
//  Per job: copies gate-context words from an instruction buffer into QEA ctx RAM, initialises the state RAM to |0...0>, pulses start, and waits for o_complete.
//  It then streams every state RAM word out through a valid/ready result port.

---
 rtl/qea_job_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_qea_job_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_job_sequencer.sv
// qea_job_sequencer: runs one complete QEA circuit job without host help.
// Copies gate-context words from the instruction buffer into QEA ctx RAM,
// initialises the state RAM to |0...0>, starts the QEA, waits for completion
// and streams every state word out of the result port.
// Optional build macro QEA_SEQ_CYCLE_CNT_EN adds o_exec_cycles (QEA run length).
// Result port handshake: a word transfers on a cycle where o_res_valid and
// i_res_ready are both high; once raised, o_res_valid stays high and
// o_res_data/o_res_last stay stable until that transfer happens.
module qea_job_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_job_start,
    input  logic                                 i_abort,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic                                 o_src_rd,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_src_addr,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_src_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_qea_start,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_res_valid,
    input  logic                                 i_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
    output logic                                 o_res_last,
`ifdef QEA_SEQ_CYCLE_CNT_EN
    output logic [31:0]                          o_exec_cycles,
`endif
    output logic [3:0]                           o_fsm_state
);

    localparam int SW    = PE_NUM * STATE_DATA_WIDTH;
    localparam int CNT_W = ((GATE_CONTEXT_ADDR_WIDTH > STATE_ADDR_WIDTH) ?
                            GATE_CONTEXT_ADDR_WIDTH : STATE_ADDR_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] ONE_RE = DATA_WIDTH'(1) << NUM_FRAC_BIT;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD_CTX, S_INIT_ST, S_START,
        S_WAIT, S_RD_ISSUE, S_RD_HOLD, S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [MAX_QBIT_WIDTH-1:0]          qbit_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
    logic                               held_q;
    logic [SW-1:0]                      res_hold_q;
    logic [CNT_W-1:0]                   last_word;
    logic                               qbit_bad;
    logic                               accept;

    // Index of the last state word: N-1 with N = 2**(qbit-PE_NUM_WIDTH).
    assign last_word = (CNT_W'(1) << (qbit_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH))) - CNT_W'(1);
    assign qbit_bad  = (32'(qbit_q) < PE_NUM_WIDTH) ||
                       (32'(qbit_q) > STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    assign accept    = (state_q == S_IDLE) && i_job_start;
    assign o_fsm_state = state_q;

    // Next-state, counter and all strobe/data outputs for the job sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done        = 1'b0;
        o_err         = 1'b0;
        o_src_rd      = 1'b0;
        o_src_addr    = '0;
        o_ctx_en      = 1'b0;
        o_ctx_wea     = 1'b0;
        o_ctx_addr    = '0;
        o_ctx_data    = '0;
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        o_qea_start   = 1'b0;
        o_res_valid   = 1'b0;
        o_res_data    = '0;
        o_res_last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_job_start) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (qbit_bad) begin
                    o_err   = 1'b1;
                    state_d = S_IDLE;
                end else if (ins_q == '0) begin
                    state_d = S_INIT_ST;
                end else begin
                    state_d = S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: begin
                // Reads run at cnt, writes trail by one cycle to meet read latency.
                if (cnt_q < CNT_W'(ins_q)) begin
                    o_src_rd   = 1'b1;
                    o_src_addr = cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
                end
                if (cnt_q != '0) begin
                    o_ctx_en   = 1'b1;
                    o_ctx_wea  = 1'b1;
                    o_ctx_addr = cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0] - GATE_CONTEXT_ADDR_WIDTH'(1);
                    o_ctx_data = i_src_data;
                end
                if (cnt_q == CNT_W'(ins_q)) begin
                    state_d = S_INIT_ST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_INIT_ST: begin
                o_state_ena   = '1;
                o_state_wea   = '1;
                o_state_addra = cnt_q[STATE_ADDR_WIDTH-1:0];
                if (cnt_q == '0) begin
                    o_state_dina[SW-1 -: STATE_DATA_WIDTH] = {ONE_RE, DATA_WIDTH'(0)};
                end
                if (cnt_q == last_word) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                o_qea_start = 1'b1;
                state_d     = S_WAIT;
                cnt_d       = '0;
            end
            S_WAIT: begin
                // The completion level may still be high from the previous job.
                if (cnt_q < CNT_W'(2)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (i_qea_complete) begin
                    state_d = S_RD_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_RD_ISSUE: begin
                o_state_ena   = '1;
                o_state_addra = cnt_q[STATE_ADDR_WIDTH-1:0];
                state_d       = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                o_res_valid = 1'b1;
                o_res_data  = held_q ? res_hold_q : i_state_dout;
                o_res_last  = (cnt_q == last_word);
                if (i_res_ready) begin
                    if (cnt_q == last_word) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_ISSUE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // State register, shared counter and job parameters sampled at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qbit_q  <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                qbit_q <= i_qbit_num;
                ins_q  <= i_ins_num;
            end
        end
    end

    // Freeze the first read-back word so it stays stable while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q     <= 1'b0;
            res_hold_q <= '0;
        end else begin
            held_q <= (state_q == S_RD_HOLD) && (state_d == S_RD_HOLD);
            if ((state_q == S_RD_HOLD) && !held_q) begin
                res_hold_q <= i_state_dout;
            end
        end
    end

`ifdef QEA_SEQ_CYCLE_CNT_EN
    logic [31:0] exec_q;

    // Saturating QEA run length: START cycle counts as 1, up to first complete seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_q <= '0;
        end else if (accept) begin
            exec_q <= '0;
        end else if (state_q == S_START) begin
            exec_q <= 32'd1;
        end else if ((state_q == S_WAIT) && (exec_q != '1)) begin
            exec_q <= exec_q + 32'd1;
        end
    end

    assign o_exec_cycles = exec_q;
`endif

endmodule

// File: tb/tb_qea_job_sequencer.sv
// tb_qea_job_sequencer: directed bench for qea_job_sequencer with models of the
// instruction buffer, the QEA state RAM and a QEA that rewrites state on start.
module tb_qea_job_sequencer;

    localparam int SW = 256;

    logic            clk;
    logic            rst;
    logic            i_job_start;
    logic            i_abort;
    logic [5:0]      i_qbit_num;
    logic [15:0]     i_ins_num;
    logic            o_busy;
    logic            o_done;
    logic            o_err;
    logic            o_src_rd;
    logic [15:0]     o_src_addr;
    logic [63:0]     i_src_data;
    logic            o_ctx_en;
    logic            o_ctx_wea;
    logic [15:0]     o_ctx_addr;
    logic [63:0]     o_ctx_data;
    logic [3:0]      o_state_ena;
    logic [3:0]      o_state_wea;
    logic [15:0]     o_state_addra;
    logic [SW-1:0]   o_state_dina;
    logic            o_qea_start;
    logic            i_qea_complete;
    logic [SW-1:0]   i_state_dout;
    logic            o_res_valid;
    logic            i_res_ready;
    logic [SW-1:0]   o_res_data;
    logic            o_res_last;
`ifdef QEA_SEQ_CYCLE_CNT_EN
    logic [31:0]     o_exec_cycles;
`endif
    logic [3:0]      o_fsm_state;

    qea_job_sequencer dut (
        .clk(clk), .rst(rst),
        .i_job_start(i_job_start), .i_abort(i_abort),
        .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_src_rd(o_src_rd), .o_src_addr(o_src_addr), .i_src_data(i_src_data),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
        .o_qea_start(o_qea_start), .i_qea_complete(i_qea_complete),
        .i_state_dout(i_state_dout),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_last(o_res_last),
`ifdef QEA_SEQ_CYCLE_CNT_EN
        .o_exec_cycles(o_exec_cycles),
`endif
        .o_fsm_state(o_fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- models / helpers ----------------
    function automatic logic [63:0] srcw(input logic [15:0] a);
        return {a * 16'h9E37, 16'hBEEF, ~a, a};
    endfunction

    // State contents the modelled QEA leaves behind after a run.
    function automatic logic [SW-1:0] pat(input int k);
        logic [SW-1:0] w;
        for (int l = 0; l < 4; l++) begin
            w[l*64 +: 64] = {32'hA0000000 + 32'(k * 16 + l), 32'h0F000000 ^ 32'(k * 7 + l * 3)};
        end
        return w;
    endfunction

    localparam logic [SW-1:0] INIT_W0 = {64'h40000000_00000000, 192'h0};

    logic          mon_clr;
    int            ready_mode;
    int            tcnt;
    int            cyc;
    logic [SW-1:0] mem [0:63];
    logic          prev_rd;
    logic [15:0]   prev_addr;
    int            ctx_n, ctx_bad, init_n, init_bad, rd_n, got_n, stab_bad;
    int            done_n, done_cyc, hs_cyc, err_n, start_n;
    logic [63:0]   init_w0;
    logic [SW-1:0] got_data [0:63];
    logic          got_last [0:63];
    logic          pv, pr;
    logic [SW-1:0] pd;
    logic          any_strobe;
    logic          any_out;

    assign any_strobe = |{o_src_rd, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea,
                          o_qea_start, o_res_valid};
    assign any_out = |{o_busy, o_done, o_err, o_src_rd, o_src_addr, o_ctx_en, o_ctx_wea,
                       o_ctx_addr, o_ctx_data, o_state_ena, o_state_wea, o_state_addra,
                       o_state_dina, o_qea_start, o_res_valid, o_res_data, o_res_last};

    // Result sink ready: always, or one cycle in three.
    always @(negedge clk) begin
        tcnt = tcnt + 1;
        i_res_ready = (ready_mode == 0) ? 1'b1 : ((tcnt % 3) == 0);
    end

    // Buffer/RAM models and monitors.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        i_src_data <= o_src_rd ? srcw(o_src_addr) : 64'h0;
        prev_rd    <= o_src_rd;
        prev_addr  <= o_src_addr;
        if (o_state_ena == 4'hF && o_state_wea == 4'h0)
            i_state_dout <= mem[o_state_addra[5:0]];
        else
            i_state_dout <= {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
        if (o_state_ena == 4'hF && o_state_wea == 4'hF)
            mem[o_state_addra[5:0]] <= o_state_dina;
        if (o_qea_start)
            for (int k = 0; k < 64; k++) mem[k] <= pat(k);
        if (mon_clr) begin
            ctx_n <= 0; ctx_bad <= 0; init_n <= 0; init_bad <= 0; rd_n <= 0;
            got_n <= 0; stab_bad <= 0; done_n <= 0; done_cyc <= 0; hs_cyc <= 0;
            err_n <= 0; start_n <= 0; init_w0 <= '0;
        end else begin
            if (o_ctx_en || o_ctx_wea) begin
                ctx_n <= ctx_n + 1;
                if (!(o_ctx_en && o_ctx_wea && o_ctx_addr == 16'(ctx_n) &&
                      o_ctx_data == srcw(o_ctx_addr) && prev_rd && prev_addr == o_ctx_addr))
                    ctx_bad <= ctx_bad + 1;
            end
            if (o_state_wea != 4'h0) begin
                init_n <= init_n + 1;
                if (init_n == 0) init_w0 <= o_state_dina[255:192];
                if (!(o_state_ena == 4'hF && o_state_wea == 4'hF && o_state_addra == 16'(init_n) &&
                      o_state_dina == ((init_n == 0) ? INIT_W0 : '0)))
                    init_bad <= init_bad + 1;
            end
            if (o_state_ena == 4'hF && o_state_wea == 4'h0) rd_n <= rd_n + 1;
            if (o_res_valid && i_res_ready) begin
                got_data[got_n[5:0]] <= o_res_data;
                got_last[got_n[5:0]] <= o_res_last;
                got_n  <= got_n + 1;
                hs_cyc <= cyc;
            end
            if (pv && !pr && (!o_res_valid || o_res_data != pd)) stab_bad <= stab_bad + 1;
            if (o_done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
            if (o_err) err_n <= err_n + 1;
            if (o_qea_start) start_n <= start_n + 1;
        end
        pv <= o_res_valid;
        pr <= i_res_ready;
        pd <= o_res_data;
    end

    // ---------------- scoreboard / checking ----------------
    int n_total;
    int n_bad;

    task automatic check_eq(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitors();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // w: cycle number (START cycle = 1) on which completion is first seen.
    task automatic run_job(input int q, input int ins, input int w, input int mode, input bit poke);
        int n;
        int t;
        int early;
        logic [SW-1:0] exp_q[$];
        n = 1 << (q - 2);
        ready_mode = mode;
        i_qea_complete = 1'b1;
        clear_monitors();
        i_qbit_num  = 6'(q);
        i_ins_num   = 16'(ins);
        i_job_start = 1'b1;
        @(negedge clk);
        i_job_start = 1'b0;
        t = 0;
        while (!o_qea_start && t < ins + n + 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("qea_start", o_qea_start, 1);
        early = 0;
        for (int c = 2; c <= w; c++) begin
            @(negedge clk);
            if (o_state_ena != 4'h0) early++;
            if (c == 4) i_qea_complete = 1'b0;
            if (poke && c == 10) begin
                i_qbit_num  = 6'd1;
                i_job_start = 1'b1;
            end
            if (poke && c == 11) i_job_start = 1'b0;
            if (c == w) i_qea_complete = 1'b1;
        end
        check_eq("no_early_rd", early, 0);
        @(negedge clk);
        check_eq("wait_exit", (o_state_ena == 4'hF && o_state_wea == 4'h0), 1);
`ifdef QEA_SEQ_CYCLE_CNT_EN
        check_eq("exec_cycles", o_exec_cycles, w);
`endif
        t = 0;
        while (!o_done && t < 4 * n + 40) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", o_done, 1);
        @(negedge clk);
        check_eq("busy_after", o_busy, 0);
        check_eq("ctx_count", ctx_n, ins);
        check_eq("ctx_bad", ctx_bad, 0);
        check_eq("init_count", init_n, n);
        check_eq("init_bad", init_bad, 0);
        check_eq("init_w0_lane3", init_w0, 64'h40000000_00000000);
        check_eq("read_count", rd_n, n);
        check_eq("res_count", got_n, n);
        check_eq("res_stable", stab_bad, 0);
        check_eq("done_once", done_n, 1);
        check_eq("done_lag", done_cyc - hs_cyc, 1);
        check_eq("no_err", err_n, 0);
        for (int k = 0; k < n; k++) exp_q.push_back(pat(k));
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("res_data[%0d]", k), got_data[k], exp_q.pop_front());
            check_eq($sformatf("res_last[%0d]", k), got_last[k], (k == n - 1));
        end
    endtask

    task automatic run_err(input int q);
        clear_monitors();
        i_qbit_num  = 6'(q);
        i_ins_num   = 16'd4;
        i_job_start = 1'b1;
        @(negedge clk);
        i_job_start = 1'b0;
        check_eq($sformatf("err_pulse_q%0d", q), o_err, 1);
        check_eq($sformatf("err_no_strobe_q%0d", q), any_strobe, 0);
        @(negedge clk);
        check_eq($sformatf("err_busy_low_q%0d", q), o_busy, 0);
        check_eq($sformatf("err_one_cycle_q%0d", q), o_err, 0);
        repeat (5) @(negedge clk);
        check_eq($sformatf("err_no_activity_q%0d", q), start_n + init_n + ctx_n, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        n_total = 0; n_bad = 0; tcnt = 0; cyc = 0; ready_mode = 0;
        mon_clr = 1'b1;
        rst = 1'b1; i_job_start = 1'b0; i_abort = 1'b0;
        i_qbit_num = '0; i_ins_num = '0; i_qea_complete = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", any_out, 0);
        check_eq("rst_fsm_idle", o_fsm_state, 0);
        rst = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", o_busy, 0);

        // 6 qubits, 205 ctx words, 500-cycle run, second start poked mid-run.
        run_job(6, 205, 500, 0, 1'b1);
        // 5 qubits, sink ready one cycle in three.
        run_job(5, 3, 20, 1, 1'b0);
        // Smallest job: no ctx words, a single state word.
        run_job(2, 0, 6, 0, 1'b0);

        // Qubit counts just outside the legal range.
        run_err(1);
        run_err(19);

        // Abort while loading ctx word 50.
        clear_monitors();
        i_qbit_num = 6'd4; i_ins_num = 16'd100; i_job_start = 1'b1;
        @(negedge clk);
        i_job_start = 1'b0;
        t = 0;
        while (!(o_src_rd && o_src_addr == 16'd50) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("abort_reach_50", o_src_addr, 50);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check_eq("abort_strobes_low", any_strobe, 0);
        check_eq("abort_busy_low", o_busy, 0);
        repeat (20) @(negedge clk);
        check_eq("abort_no_done", done_n, 0);
        check_eq("abort_ctx_count", ctx_n, 50);
        check_eq("abort_no_start", start_n, 0);

        // Asynchronous reset in the middle of WAIT.
        i_qea_complete = 1'b0;
        i_qbit_num = 6'd3; i_ins_num = 16'd2; i_job_start = 1'b1;
        @(negedge clk);
        i_job_start = 1'b0;
        t = 0;
        while (!o_qea_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("rstwait_start", o_qea_start, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rstwait_outputs", any_out, 0);
        check_eq("rstwait_fsm_idle", o_fsm_state, 0);
        @(negedge clk);
        rst = 1'b0;

        // Start and abort together in IDLE: the start is taken.
        @(negedge clk);
        i_qbit_num = 6'd2; i_ins_num = 16'd0;
        i_job_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_job_start = 1'b0; i_abort = 1'b0;
        check_eq("start_beats_abort", o_busy, 1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check_eq("abort_after_start", o_busy, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
